// File: rtl/inj_fifo_ni.sv
// Network-interface injection FIFO: captures strobed 20-bit words, prepends NODE_ID and
// hands flits to the router over valid/ready. Optional counters via NI_STATS_EN.
module inj_fifo_ni #(
   parameter int unsigned DEPTH    = 8,
   parameter logic [3:0]  NODE_ID  = 4'h0,
   parameter int unsigned MAX_DEST = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] in_data,
   input  logic        in_valid,
   output logic [23:0] out_flit,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        empty,
   output logic        full,
   output logic        ovf_err,
   output logic        dest_err,
   output logic [15:0] acc_cnt,
   output logic [15:0] drop_cnt
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [19:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [23:0]   flit_q, flit_d;
   logic          valid_q, valid_d;
   logic          empty_q, empty_d, full_q, full_d;
   logic          ovf_q, ovf_d, dest_err_q, dest_err_d;
   logic          dest_ok, pop, push, stored, load_out, wr_mem;

   always_comb begin
      dest_ok  = (32'(in_data[3:0]) <= MAX_DEST);
      pop      = valid_q & out_ready;
      push     = in_valid & dest_ok & ((count_q < DEPTH_C) | pop);
      // count includes the output register, so storage holds words beyond that one
      stored   = (count_q > {{(CW-1){1'b0}}, valid_q});
      load_out = ~valid_q | pop;

      flit_d   = flit_q;
      valid_d  = valid_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      wr_mem   = 1'b0;

      if (load_out) begin
         if (stored) begin
            flit_d   = {NODE_ID, mem[rd_ptr_q]};
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else if (push) begin
            flit_d  = {NODE_ID, in_data};
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end

      // Bypassed words skip storage entirely
      if (push && !(load_out && !stored)) begin
         wr_mem   = 1'b1;
         wr_ptr_d = wr_ptr_q + PW'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      empty_d    = (count_d == '0);
      full_d     = (count_d == DEPTH_C);
      ovf_d      = ovf_q | (in_valid & dest_ok & ~push);
      dest_err_d = dest_err_q | (in_valid & ~dest_ok);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         flit_q     <= '0;
         valid_q    <= 1'b0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         dest_err_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         flit_q     <= flit_d;
         valid_q    <= valid_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         ovf_q      <= ovf_d;
         dest_err_q <= dest_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_mem) begin
         mem[wr_ptr_q] <= in_data;
      end
   end

   assign out_flit  = flit_q;
   assign out_valid = valid_q;
   assign empty     = empty_q;
   assign full      = full_q;
   assign ovf_err   = ovf_q;
   assign dest_err  = dest_err_q;

`ifdef NI_STATS_EN
   logic [15:0] acc_q, drop_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q  <= '0;
         drop_q <= '0;
      end else begin
         if (push && (acc_q != 16'hFFFF)) begin
            acc_q <= acc_q + 16'd1;
         end
         if (in_valid && !push && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
         end
      end
   end

   assign acc_cnt  = acc_q;
   assign drop_cnt = drop_q;
`else
   assign acc_cnt  = '0;
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_inj_fifo_ni.sv
// Randomized and directed bench for inj_fifo_ni against a queue-based reference model.
module tb_inj_fifo_ni;

   localparam logic [3:0] NID = 4'h5;
   localparam int DEPTH = 8;
   localparam int MAXD = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [19:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic [23:0] out_flit;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        empty, full, ovf_err, dest_err;
   logic [15:0] acc_cnt, drop_cnt;

   always #5 clk = ~clk;

   inj_fifo_ni #(
      .DEPTH    (DEPTH),
      .NODE_ID  (NID),
      .MAX_DEST (MAXD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_flit  (out_flit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .empty     (empty),
      .full      (full),
      .ovf_err   (ovf_err),
      .dest_err  (dest_err),
      .acc_cnt   (acc_cnt),
      .drop_cnt  (drop_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: every held word in arrival order, head is the one on out_flit
   logic [19:0] q[$];
   bit          m_ovf, m_dst;
   int          m_acc, m_drop;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] stat(input int v);
`ifdef NI_STATS_EN
      return (v > 65535) ? 32'hFFFF : 32'(v);
`else
      return 32'(v - v);
`endif
   endfunction

   task automatic check_all();
      check_val("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) check_val("out_flit", 32'(out_flit), 32'({NID, q[0]}));
      check_val("empty", 32'(empty), 32'(q.size() == 0));
      check_val("full", 32'(full), 32'(q.size() == DEPTH));
      check_val("ovf_err", 32'(ovf_err), 32'(m_ovf));
      check_val("dest_err", 32'(dest_err), 32'(m_dst));
      check_val("acc_cnt", 32'(acc_cnt), stat(m_acc));
      check_val("drop_cnt", 32'(drop_cnt), stat(m_drop));
   endtask

   task automatic step(input logic v, input logic [19:0] d, input logic r);
      bit pop, dok, push;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      pop  = (q.size() > 0) && r;
      dok  = (int'(d[3:0]) <= MAXD);
      push = v && dok && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
         q.push_back(d);
         m_acc++;
      end
      if (v && !push) m_drop++;
      if (v && !dok) m_dst = 1'b1;
      if (v && dok && !push) m_ovf = 1'b1;
      #1;
      check_all();
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst = 1'b0;
      #2;
      q.delete();
      m_ovf = 0; m_dst = 0; m_acc = 0; m_drop = 0;
      check_all();
      check_val("rst_flit", 32'(out_flit), 32'h0);
      rst = 1'b1;
      #1;
   endtask

   initial begin
      int phase_bias;
      m_ovf = 0; m_dst = 0; m_acc = 0; m_drop = 0;
      #12;
      check_all();
      check_val("rst_flit", 32'(out_flit), 32'h0);
      rst = 1'b1;

      // Single word straight through
      step(1'b1, 20'h02010, 1'b1);
      check_val("single_flit", 32'(out_flit), 32'({NID, 20'h02010}));
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      // Back-to-back stream with ready held high
      for (int i = 0; i < 30; i++) step(1'b1, 20'h02010 + 20'(16 * i), 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

      // Overflow: 10 words into a stalled block, then drain
      for (int i = 0; i < 10; i++) step(1'b1, 20'h0A000 + 20'(16 * i + 1), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

      // Full with same-edge pop and push must accept without overflow
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 20'h0B000 + 20'(16 * i + 2), 1'b0);
      step(1'b1, 20'h0BFF3, 1'b1);
      step(1'b0, '0, 1'b0);

      // Illegal destination word followed by legal ones
      for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1);
      step(1'b1, 20'h12345, 1'b1);
      step(1'b1, 20'h12343, 1'b1);
      step(1'b1, 20'h12340, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      // Asynchronous reset while 5 words are held
      for (int i = 0; i < 5; i++) step(1'b1, 20'h0C000 + 20'(16 * i), 1'b0);
      do_reset();

      // Randomized traffic with varying backpressure
      phase_bias = 1;
      for (int i = 0; i < 3000; i++) begin
         logic        v, r;
         logic [3:0]  dst;
         if (i % 200 == 0) phase_bias = int'($urandom_range(0, 3));
         v   = ($urandom_range(0, 3) != 0);
         dst = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         r   = ($urandom_range(0, 3) < phase_bias) || (phase_bias == 3);
         step(v, {16'($urandom), dst}, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
